i2c_slave_e2prom: RTL and testbench
===================================

// Module: i2c_slave_e2prom
// PURPOSE
//  I2C target that emulates a 24Cxx-style E2PROM so the I2C master and the e2prom_rw test can run
//  in simulation or on-board loopback without a real device. Contents are held in an internal
//  register array. Supports byte/page writes, random/current/sequential reads and repeated START.
//  Runs on the fast system clock and oversamples the bus. Instantiated beside the master in the
//  loopback top level.
// PARAMETERS
//  SLAVE_ADDR  7'b1010000  7-bit device address the block responds to
//  BIT_CTRL    1'b1        word address width: 1 = 16-bit (high then low byte), 0 = 8-bit
//  MEM_AW      8           memory address bits; depth 2**MEM_AW bytes
// PORTS
//  sys_clk    in     1       system clock; must be at least 20x the SCL frequency
//  sys_rst_n  in     1       asynchronous active-low reset
//  iic_scl    in     1       I2C clock from the master; never stretched
//  iic_sda    inout  1       I2C data, open-drain: driven 1'b0 or 1'bz, never 1'b1
//  wr_en      out    1       one-cycle pulse when a data byte is committed to memory
//  wr_addr    out    16      address of the committed byte, zero-extended
//  wr_data    out    8       the committed byte
//  busy       out    1       high from an addressed START until STOP
// BEHAVIOUR
//  - Reset (async): all outputs 0, SDA released, state IDLE, pointer 0, memory cleared to 8'h00.
//  - Bus sampling: SCL/SDA pass a 2-FF synchroniser plus one history stage.
//    START = SDA falls while SCL high. STOP = SDA rises while SCL high.
//    Data is sampled on the SCL rising edge. SDA is changed one cycle after the SCL falling edge.
//  - States: IDLE, DEV, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL, WR, ACK_WR, RD, MACK, IGNORE.
//  - START from any state -> DEV with the bit counter cleared (repeated START).
//    STOP from any state -> IDLE with SDA released.
//  - DEV: shift 8 bits, MSB first.
//    Address match -> ACK_DEV (pull SDA low for the 9th clock). No match -> IGNORE until START/STOP.
//  - After ACK_DEV:
//    R/W=0 -> ADDR_H if BIT_CTRL=1, otherwise ADDR_L.
//    R/W=1 -> RD; the byte at the pointer is loaded and MSB is driven after the ACK clock falls.
//  - ADDR_H/ADDR_L: each byte is ACKed. After ADDR_L the pointer = {hi,lo}[MEM_AW-1:0].
//    Upper address bits beyond MEM_AW are ignored.
//  - WR: each received byte is ACKed, written to mem[ptr] on the 8th SCL rise, and ptr increments.
//    wr_en pulses in that same cycle, with wr_addr = ptr before the increment.
//  - RD: drive 8 bits, then release SDA for MACK and sample it.
//    ACK(0): ptr++, next byte -> RD. NACK(1): -> IGNORE (wait for STOP/START).
//  - Pointer wraps from 2**MEM_AW-1 to 0 on both read and write. There is no page-boundary wrap.
//  - A read after STOP with no address phase uses the current pointer (current-address read).
//  - A partial byte aborted by START/STOP is discarded and never written.
//  - Reset asserted mid-transfer releases SDA in the same cycle (async).
//  - busy rises on the address-match cycle and falls on STOP detect.
// CONFIGURATION
//  I2C_SLV_WP_EN defined:
//   - Adds input port wp (1 bit, synchronised with 2 FFs).
//   - While wp=1, data bytes in WR are NACKed, not written, and wr_en stays 0.
//   - The address phases are still ACKed.
//  Not defined: no wp port; all writes are accepted.
// STRUCTURE
//  - Package i2c_slv_pkg: state enum/localparams, ACK/NACK constants, a BYTE_W=8 constant.
//  - Sub-module i2c_slv_sync: 2-FF sync of SCL/SDA plus edge flags
//    (scl_rise, scl_fall, start_det, stop_det).
//  - Top level holds the FSM, bit counter, shift registers, pointer and memory array.
// TESTING
//  - Write 0x1234=0xA5: START,0xA0,0x12,0x34,0xA5,STOP -> 4 ACKs; wr_en once with
//    wr_addr=0x0034 (MEM_AW=8), wr_data=0xA5.
//  - Random read: START,0xA0,0x00,0x34,rSTART,0xA1, read, NACK, STOP -> data 0xA5; busy low after STOP.
//  - Sequential: write 0x01..0x04 at 0x00FE -> memory 0xFE/0xFF/0x00/0x01 hold them (wrap);
//    read 4 from 0x00FE -> 01,02,03,04.
//  - Wrong address 0xA2 -> SDA never driven; a following valid transfer to 0xA0 is ACKed.
//  - Mid-byte STOP after 5 data bits -> no wr_en and memory unchanged. sys_rst_n low mid-read
//    -> SDA released; all outputs 0.
//  - I2C_SLV_WP_EN, wp=1: write 0x55 -> address phases ACKed, data NACKed, no wr_en; read back 0x00.
//  - Run each case at SCL 250 kHz and at 50 MHz sys_clk, driven by the i2c_dri master.

Source files
------------

// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the I2C E2PROM target.
package i2c_slv_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_ACK_DEV,
    S_ADDR_H,
    S_ACK_AH,
    S_ADDR_L,
    S_ACK_AL,
    S_WR,
    S_ACK_WR,
    S_RD,
    S_MACK,
    S_IGNORE
  } state_e;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   BYTE_W = 8;

  // Receive states shift eight bits from SDA before their ACK slot.
  function automatic logic is_rx_state(input state_e s);
    return (s == S_DEV) || (s == S_ADDR_H) || (s == S_ADDR_L) || (s == S_WR);
  endfunction

endpackage

// File: rtl/i2c_slv_sync.sv
// Two-flop synchroniser for SCL/SDA plus one history stage; flags edges and START/STOP.
module i2c_slv_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_m_q, scl_s_q, scl_h_q;
  logic sda_m_q, sda_s_q, sda_h_q;
  logic scl_m_d, scl_s_d, scl_h_d;
  logic sda_m_d, sda_s_d, sda_h_d;

  always_comb begin
    scl_m_d = scl_in;
    scl_s_d = scl_m_q;
    scl_h_d = scl_s_q;
    sda_m_d = sda_in;
    sda_s_d = sda_m_q;
    sda_h_d = sda_s_q;
  end

  // Idle bus level is high, so reset to 1 to avoid a false START after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_h_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_h_q <= 1'b1;
    end else begin
      scl_m_q <= scl_m_d;
      scl_s_q <= scl_s_d;
      scl_h_q <= scl_h_d;
      sda_m_q <= sda_m_d;
      sda_s_q <= sda_s_d;
      sda_h_q <= sda_h_d;
    end
  end

  assign sda_s     = sda_s_q;
  assign scl_rise  = scl_s_q & ~scl_h_q;
  assign scl_fall  = ~scl_s_q & scl_h_q;
  assign start_det = scl_s_q & scl_h_q & sda_h_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_h_q & ~sda_h_q & sda_s_q;

endmodule

// File: rtl/i2c_slave_e2prom.sv
// 24Cxx-style E2PROM target on an oversampled I2C bus; SDA is open-drain, SCL never stretched.
// Defining I2C_SLV_WP_EN adds a synchronised wp input that NACKs and drops data bytes.
module i2c_slave_e2prom
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000,
  parameter logic       BIT_CTRL   = 1'b1,
  parameter int         MEM_AW     = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        iic_scl,
  inout  wire         iic_sda,
`ifdef I2C_SLV_WP_EN
  input  logic        wp,
`endif
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int DEPTH = 1 << MEM_AW;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic wp_s;

  i2c_slv_sync u_sync (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .scl_in    (iic_scl),
    .sda_in    (iic_sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

`ifdef I2C_SLV_WP_EN
  logic wp_m_q, wp_s_q, wp_m_d, wp_s_d;
  assign wp_m_d = wp;
  assign wp_s_d = wp_m_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wp_m_q <= 1'b0;
      wp_s_q <= 1'b0;
    end else begin
      wp_m_q <= wp_m_d;
      wp_s_q <= wp_s_d;
    end
  end
  assign wp_s = wp_s_q;
`else
  assign wp_s = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          addr_h_q, addr_h_d;
  logic [7:0]          tx_q, tx_d;
  logic [MEM_AW-1:0]   ptr_q, ptr_d;
  logic                rw_q, rw_d;
  logic                nack_q, nack_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic [15:0]         wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          mem_q [DEPTH];
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_wa;
  logic [7:0]          mem_wd;

  logic [7:0]          rx_byte;
  logic [15:0]         addr_word;
  logic [MEM_AW-1:0]   ptr_inc;

  assign rx_byte   = {shift_q[6:0], sda_s};
  assign addr_word = BIT_CTRL ? {addr_h_q, rx_byte} : {8'h00, rx_byte};
  assign ptr_inc   = ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_h_d  = addr_h_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    mem_wa    = ptr_q;
    mem_wd    = rx_byte;

    if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_DEV;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (is_rx_state(state_q)) begin
      if (scl_rise) begin
        shift_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(BYTE_W - 1)) begin
          bit_cnt_d = '0;
          nack_d    = ACK;
          if (state_q == S_DEV) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              rw_d    = rx_byte[0];
              busy_d  = 1'b1;
              state_d = S_ACK_DEV;
            end else begin
              state_d = S_IGNORE;
            end
          end else if (state_q == S_ADDR_H) begin
            addr_h_d = rx_byte;
            state_d  = S_ACK_AH;
          end else if (state_q == S_ADDR_L) begin
            ptr_d   = addr_word[MEM_AW-1:0];
            state_d = S_ACK_AL;
          end else begin
            state_d = S_ACK_WR;
            if (wp_s) begin
              nack_d = NACK;
            end else begin
              mem_we    = 1'b1;
              wr_en_d   = 1'b1;
              wr_addr_d = 16'(ptr_q);
              wr_data_d = rx_byte;
              ptr_d     = ptr_inc;
            end
          end
        end
      end
    end else begin
      case (state_q)
        S_ACK_DEV, S_ACK_AH, S_ACK_AL, S_ACK_WR: begin
          // bit_cnt marks whether the 9th SCL rise has been seen yet.
          if (scl_rise) begin
            bit_cnt_d = 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d = (nack_q == ACK);
            end else begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              if (state_q == S_ACK_DEV) begin
                if (rw_q) begin
                  state_d  = S_RD;
                  tx_d     = mem_q[ptr_q];
                  sda_oe_d = ~mem_q[ptr_q][7];
                end else begin
                  state_d = BIT_CTRL ? S_ADDR_H : S_ADDR_L;
                end
              end else if (state_q == S_ACK_AH) begin
                state_d = S_ADDR_L;
              end else begin
                state_d = S_WR;
              end
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'(BYTE_W)) begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              state_d   = S_MACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            nack_d    = sda_s;
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if (nack_q == ACK) begin
              ptr_d    = ptr_inc;
              tx_d     = mem_q[ptr_inc];
              sda_oe_d = ~mem_q[ptr_inc][7];
              state_d  = S_RD;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_h_q  <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      nack_q    <= ACK;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_h_q  <= addr_h_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign iic_sda = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave_e2prom.sv
// Bench for i2c_slave_e2prom: bit-banged I2C master, transaction-level memory model, random traffic.
module tb_i2c_slave_e2prom;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda_low = 1'b0;
  wire         sda_bus;
  logic        wr_en, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
`ifdef I2C_SLV_WP_EN
  logic        wp = 1'b0;
`endif

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_e2prom dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .iic_scl   (scl),
    .iic_sda   (sda_bus),
`ifdef I2C_SLV_WP_EN
    .wp        (wp),
`endif
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #10 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  int          q = 8;
  int          slave_drove = 0;
  logic [7:0]  mdl_mem [256];
  logic [7:0]  mdl_ptr = 8'h00;
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  logic [7:0]  wbuf [8];
  logic [7:0]  rbuf [8];

  always @(negedge sys_clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (!m_sda_low && sda_bus === 1'b0) slave_drove++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b0; tick(q);
    scl = 1'b1;       tick(q);
    m_sda_low = 1'b1; tick(q);
    scl = 1'b0;       tick(q);
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1; tick(q);
    scl = 1'b1;       tick(q);
    m_sda_low = 1'b0; tick(2 * q);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; tick(q);
    scl = 1'b1;     tick(2 * q);
    scl = 1'b0;     tick(q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; tick(q);
    scl = 1'b1;       tick(q);
    b = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    tick(q);
    scl = 1'b0;       tick(q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // Write wbuf[0..n-1] at addr; the model applies the same bytes with 8-bit pointer wrap.
  task automatic write_txn(input logic [15:0] addr, input int n, output int naks);
    logic a;
    naks = 0;
    i2c_start;
    send_byte(8'hA0, a);      naks += a;
    send_byte(addr[15:8], a); naks += a;
    send_byte(addr[7:0], a);  naks += a;
    mdl_ptr = addr[7:0];
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a);  naks += a;
      mdl_mem[mdl_ptr] = wbuf[i];
      mdl_ptr = mdl_ptr + 8'd1;
    end
    i2c_stop;
  endtask

  // Random read of n bytes into rbuf; master ACKs all but the last byte.
  task automatic read_txn(input logic [15:0] addr, input int n, output int naks);
    logic a;
    naks = 0;
    i2c_start;
    send_byte(8'hA0, a);      naks += a;
    send_byte(addr[15:8], a); naks += a;
    send_byte(addr[7:0], a);  naks += a;
    i2c_start;
    send_byte(8'hA1, a);      naks += a;
    for (int i = 0; i < n; i++) recv_byte(rbuf[i], (i == n - 1));
    i2c_stop;
    mdl_ptr = addr[7:0] + 8'(n - 1);
  endtask

  task automatic check_readback(input string name, input logic [15:0] addr, input int n);
    int naks;
    logic [7:0] exp_b [8];
    for (int i = 0; i < n; i++) exp_b[i] = mdl_mem[8'(addr[7:0] + 8'(i))];
    read_txn(addr, n, naks);
    checks++;
    if (naks !== 0) begin errors++; $display("FAIL %s_naks got %0d want 0", name, naks); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rbuf[i] !== exp_b[i]) begin
        errors++; $display("FAIL %s_byte%0d got %02h want %02h", name, i, rbuf[i], exp_b[i]);
      end
    end
  endtask

  task automatic check_log(input string name, input logic [15:0] addr, input int n);
    checks++;
    if (log_addr.size() !== n) begin
      errors++; $display("FAIL %s_wr_en_count got %0d want %0d", name, log_addr.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (log_addr[i] !== {8'h00, 8'(addr[7:0] + 8'(i))} || log_data[i] !== wbuf[i]) begin
          errors++;
          $display("FAIL %s_wr%0d got %04h/%02h want %04h/%02h", name, i, log_addr[i], log_data[i],
                   {8'h00, 8'(addr[7:0] + 8'(i))}, wbuf[i]);
        end
      end
    end
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
    #5 sys_rst_n = 1'b0;
    tick(5);
    checks++;
    if ({wr_en, busy, wr_addr, wr_data} !== 26'd0) begin
      errors++; $display("FAIL reset_outputs got %b/%b/%h/%h want 0", wr_en, busy, wr_addr, wr_data);
    end
    checks++;
    if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda_bus); end
    sys_rst_n = 1'b1;
    tick(5);
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_write_basic;
    logic a;
    int naks = 0;
    q = 50;
    i2c_start;
    send_byte(8'hA0, a); naks += a;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_during got %b want 1", busy); end
    send_byte(8'h12, a); naks += a;
    send_byte(8'h34, a); naks += a;
    send_byte(8'hA5, a); naks += a;
    i2c_stop;
    mdl_mem[8'h34] = 8'hA5;
    wbuf[0] = 8'hA5;
    checks++;
    if (naks !== 0) begin errors++; $display("FAIL write_basic_acks got %0d nacks want 0", naks); end
    check_log("write_basic", 16'h1234, 1);
    q = 8;
  endtask

  task automatic test_random_read;
    check_readback("random_read", 16'h0034, 1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_sequential;
    int naks;
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
    write_txn(16'h00FE, 4, naks);
    checks++;
    if (naks !== 0) begin errors++; $display("FAIL seq_write_naks got %0d want 0", naks); end
    check_log("seq_write", 16'h00FE, 4);
    check_readback("seq_read", 16'h00FE, 4);
    checks++;
    if (mdl_mem[8'h00] !== 8'h03) begin errors++; $display("FAIL seq_wrap_model got %02h want 03", mdl_mem[8'h00]); end
  endtask

  task automatic test_wrong_addr;
    logic a0, a1;
    slave_drove = 0;
    i2c_start;
    send_byte(8'hA2, a0);
    send_byte(8'h00, a1);
    i2c_stop;
    checks++;
    if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL wrong_addr_ack got %b want 11", {a0, a1}); end
    checks++;
    if (slave_drove !== 0) begin errors++; $display("FAIL wrong_addr_sda got %0d cycles want 0", slave_drove); end
    check_readback("after_wrong", 16'h0034, 1);
  endtask

  task automatic test_mid_stop;
    logic a;
    int naks = 0;
    i2c_start;
    send_byte(8'hA0, a); naks += a;
    send_byte(8'h00, a); naks += a;
    send_byte(8'h34, a); naks += a;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    i2c_stop;
    mdl_ptr = 8'h34;
    checks++;
    if (naks !== 0) begin errors++; $display("FAIL mid_stop_naks got %0d want 0", naks); end
    checks++;
    if (log_addr.size() !== 0) begin errors++; $display("FAIL mid_stop_wr_en got %0d want 0", log_addr.size()); end
  endtask

  task automatic test_current_read;
    logic a;
    logic [7:0] e0, e1;
    e0 = mdl_mem[mdl_ptr];
    e1 = mdl_mem[8'(mdl_ptr + 8'd1)];
    i2c_start;
    send_byte(8'hA1, a);
    recv_byte(rbuf[0], 1'b0);
    recv_byte(rbuf[1], 1'b1);
    i2c_stop;
    mdl_ptr = mdl_ptr + 8'd1;
    checks++;
    if ({a, rbuf[0], rbuf[1]} !== {1'b0, e0, e1}) begin
      errors++; $display("FAIL current_read got %b %02h %02h want 0 %02h %02h", a, rbuf[0], rbuf[1], e0, e1);
    end
  endtask

  task automatic test_random;
    logic [15:0] addr;
    int n, naks;
    for (int t = 0; t < 5; t++) begin
      addr = 16'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_txn(addr, n, naks);
      checks++;
      if (naks !== 0) begin errors++; $display("FAIL rand%0d_write_naks got %0d want 0", t, naks); end
      check_log("rand_write", addr, n);
      check_readback("rand_read", addr, n);
    end
  endtask

  task automatic test_reset_mid_read;
    logic a, b;
    int naks;
    wbuf[0] = 8'h00;
    write_txn(16'h0080, 1, naks);
    log_addr.delete();
    log_data.delete();
    i2c_start;
    send_byte(8'hA0, a);
    send_byte(8'h00, a);
    send_byte(8'h80, a);
    i2c_start;
    send_byte(8'hA1, a);
    recv_bit(b);
    recv_bit(b);
    checks++;
    if (sda_bus !== 1'b0) begin errors++; $display("FAIL mid_read_driving got %b want 0", sda_bus); end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_release_sda got %b want 1", sda_bus); end
    checks++;
    if ({wr_en, busy, wr_addr, wr_data} !== 26'd0) begin
      errors++; $display("FAIL reset_mid_outputs got %b/%b/%h/%h want 0", wr_en, busy, wr_addr, wr_data);
    end
    tick(3);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 8'h00;
    tick(3);
    i2c_stop;
    check_readback("after_reset", 16'h0034, 1);
  endtask

`ifdef I2C_SLV_WP_EN
  task automatic test_wp;
    logic a;
    int naks = 0;
    wp = 1'b1;
    tick(4);
    i2c_start;
    send_byte(8'hA0, a); naks += a;
    send_byte(8'h00, a); naks += a;
    send_byte(8'h40, a); naks += a;
    checks++;
    if (naks !== 0) begin errors++; $display("FAIL wp_addr_naks got %0d want 0", naks); end
    send_byte(8'h55, a);
    i2c_stop;
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL wp_data_ack got %b want 1", a); end
    checks++;
    if (log_addr.size() !== 0) begin errors++; $display("FAIL wp_wr_en got %0d want 0", log_addr.size()); end
    wp = 1'b0;
    check_readback("wp_read", 16'h0040, 1);
  endtask
`endif

  initial begin
    test_reset;
    test_write_basic;
    test_random_read;
    test_sequential;
    test_wrong_addr;
    test_mid_stop;
    test_current_read;
    test_random;
    test_reset_mid_read;
`ifdef I2C_SLV_WP_EN
    test_wp;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
